// File: rtl/des_round_ctrl.sv
// des_round_ctrl: control sequencer for a DES datapath.
// It pulses the IP/PC1 load, steps NUM_ROUNDS Feistel rounds with key-schedule
// rotate controls, pulses the FP capture, and then holds out_valid until the
// consumer accepts the result. It carries no data bits.
// Optional build macro DES_ABORT_EN adds an abort input and an aborted pulse output.
module des_round_ctrl #(
  parameter int unsigned NUM_ROUNDS = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic       decrypt,
  output logic       in_ready,
  output logic       ld_ip,
  output logic       round_en,
  output logic [4:0] round_num,
  output logic [1:0] key_shift,
  output logic       key_dir,
  output logic       ld_fp,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
`ifdef DES_ABORT_EN
  ,
  input  logic       abort,
  output logic       aborted
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ROUND,
    S_FINAL,
    S_HOLD
  } state_t;

  localparam logic [4:0] LAST_ROUND = 5'(NUM_ROUNDS);

  state_t state;
  logic   mode;

  // Rotate amount for round r. Decrypt skips the round-1 rotate so that the
  // right rotations walk the encrypt subkeys in reverse order.
  function automatic logic [1:0] shift_amt(input logic [4:0] r, input logic dec);
    if (dec && (r == 5'd1))
      return 2'd0;
    if ((r == 5'd1) || (r == 5'd2) || (r == 5'd9) || (r == 5'd16))
      return 2'd1;
    return 2'd2;
  endfunction

  assign in_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);
  assign key_dir  = mode;

`ifdef DES_ABORT_EN
  logic abort_hit;
  assign abort_hit = abort && ((state == S_LOAD) || (state == S_ROUND) || (state == S_FINAL));
`endif

  // Sequencer FSM. Outputs are registered together with the state so that
  // each output always matches the state it describes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      mode      <= 1'b0;
      ld_ip     <= 1'b0;
      round_en  <= 1'b0;
      round_num <= '0;
      key_shift <= '0;
      ld_fp     <= 1'b0;
      out_valid <= 1'b0;
`ifdef DES_ABORT_EN
      aborted   <= 1'b0;
`endif
    end else begin
`ifdef DES_ABORT_EN
      aborted <= 1'b0;
      if (abort_hit) begin
        state     <= S_IDLE;
        ld_ip     <= 1'b0;
        round_en  <= 1'b0;
        round_num <= '0;
        key_shift <= '0;
        ld_fp     <= 1'b0;
        out_valid <= 1'b0;
        aborted   <= 1'b1;
      end else
`endif
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            mode  <= decrypt;
            ld_ip <= 1'b1;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          ld_ip     <= 1'b0;
          round_en  <= 1'b1;
          round_num <= 5'd1;
          key_shift <= shift_amt(5'd1, mode);
          state     <= S_ROUND;
        end
        S_ROUND: begin
          if (round_num == LAST_ROUND) begin
            round_en  <= 1'b0;
            round_num <= '0;
            key_shift <= '0;
            ld_fp     <= 1'b1;
            state     <= S_FINAL;
          end else begin
            round_num <= round_num + 5'd1;
            key_shift <= shift_amt(round_num + 5'd1, mode);
          end
        end
        S_FINAL: begin
          ld_fp     <= 1'b0;
          out_valid <= 1'b1;
          state     <= S_HOLD;
        end
        S_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
